circ_buffer_ptr_ctrl: RTL
=========================

// Module: circ_buffer_ptr_ctrl
// PURPOSE
//  Read/write pointer controller for the convolution engine's circular line/window
//  buffers; successor to the single enable-driven Pointer counter. Tracks occupancy,
//  flags full/empty, and supports mark/rewind so a window row is replayed without refetch.
//  Sits between the input streamer (writes) and the MAC array feeder (reads);
//  drives the buffer RAM addresses directly.
// PARAMETERS
//  BufferWidth  2               pointer width in bits
//  Depth        2**BufferWidth  number of entries; 2 <= Depth <= 2**BufferWidth, need not be a power of 2
//  CountWidth   BufferWidth+1   width of Count/Replay; must hold the value Depth
// PORTS
//  clk        in   1            clock; all state changes on rising edge
//  sclr       in   1            synchronous active-high reset; one clock; no async reset
//  WrEN       in   1            write request
//  RdEN       in   1            read request
//  Mark       in   1            pulse: set replay mark at current RdPointer
//  Rewind     in   1            pulse: return RdPointer to mark
//  Release    in   1            pulse: drop mark, free replay entries
//  WrAccept   out  1            comb: WrEN & ~Full
//  RdAccept   out  1            comb: RdEN & ~Empty & ~Rewind
//  WrPointer  out  BufferWidth  write address (registered)
//  RdPointer  out  BufferWidth  read address (registered)
//  Count      out  CountWidth   unread entries (registered)
//  Replay     out  CountWidth   entries read since Mark, still held
//  MarkValid  out  1            mark active
//  Full       out  1            comb: (Count + Replay) == Depth
//  Empty      out  1            comb: Count == 0
//  Err        out  1            sticky: set on WrEN&Full or RdEN&Empty (same cycle, not Rewind)
// BEHAVIOUR
//  - sclr (priority over all): WrPointer=0, RdPointer=0, Count=0, Replay=0, MarkValid=0,
//    Err=0 -> Empty=1, Full=0. Mid-operation sclr discards all state, incl. mark.
//  - Pointer advance: +1 on accept; value Depth-1 wraps to 0 (not 2**BufferWidth-1).
//  - Flags from registered state only; a same-cycle read never frees room for a write.
//  - Count: +1 on WrAccept only, -1 on RdAccept only, unchanged when both.
//  - Full & WrEN & RdEN: read accepted, write rejected. Empty & both: write only.
//  - Replay: +1 per RdAccept while MarkValid (or on the Mark cycle itself); else 0.
//    Invariant Count + Replay <= Depth; marked entries are never overwritten.
//  - Mark: MarkPtr <= RdPointer (pre-read value this cycle), MarkValid <= 1, Replay
//    restarts (0, or 1 if RdAccept same cycle). Re-Mark while valid frees old replay.
//  - Rewind (MarkValid=1): RdPointer <= MarkPtr, Count <= Count + Replay (+1 if
//    WrAccept), Replay <= 0, mark kept (repeatable). RdEN ignored that cycle.
//    Rewind with MarkValid=0: no-op except RdEN still blocked.
//  - Release: MarkValid <= 0, Replay <= 0; same-cycle RdAccept applies normally.
//  - Control priority: sclr > Rewind > Mark > Release. Losing pulse is dropped.
//  - Latency: pointers/Count/Replay update 1 cycle after accept; Full/Empty/Accept
//    follow combinationally from registers. Max one write and one read per cycle.
// TESTING  (Depth=3, BufferWidth=2 unless stated)
//  1 Reset: hold sclr 2 cycles mid-fill -> WrPointer=0, RdPointer=0, Count=0, Empty=1,
//    Full=0, MarkValid=0, Err=0.
//  2 Fill/wrap: 3 writes -> WrPointer 1,2,0; Count=3, Full=1; 4th WrEN -> WrAccept=0,
//    WrPointer stays 0, Err=1. Then 3 reads -> RdPointer 1,2,0, Empty=1.
//  3 Simultaneous: Count=1, WrEN=RdEN=1 -> Count=1, both pointers +1; at Count=3
//    -> only read accepted, Count=2; at Count=0 -> only write, Count=1.
//  4 Mark/Rewind: 3 writes, Mark at RdPointer=0, 2 reads -> Count=1, Replay=2, Full=1;
//    Rewind -> RdPointer=0, Count=3, Replay=0; 3 reads return addr 0,1,2.
//  5 Release: after step 4 reads (Replay=3, Count=0) Release -> Replay=0, Full=0,
//    Empty=1; next WrEN accepted at WrPointer=0.
//  6 Rewind+RdEN+WrEN same cycle: RdAccept=0, WrAccept=1, Count=Count+Replay+1;
//    Depth=4/BufferWidth=2 rerun of step 2 confirms wrap 3->0.

Source files
------------

// File: rtl/circ_buffer_ptr_ctrl.sv
// rtl/circ_buffer_ptr_ctrl.sv - read/write pointer controller for circular line/window buffers with mark/rewind replay
module circ_buffer_ptr_ctrl #(
    parameter int BufferWidth = 2,
    parameter int Depth       = 2**BufferWidth,
    parameter int CountWidth  = BufferWidth + 1
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic                   WrEN,
    input  logic                   RdEN,
    input  logic                   Mark,
    input  logic                   Rewind,
    input  logic                   Release,
    output logic                   WrAccept,
    output logic                   RdAccept,
    output logic [BufferWidth-1:0] WrPointer,
    output logic [BufferWidth-1:0] RdPointer,
    output logic [CountWidth-1:0]  Count,
    output logic [CountWidth-1:0]  Replay,
    output logic                   MarkValid,
    output logic                   Full,
    output logic                   Empty,
    output logic                   Err
);

    // Last legal address; pointers wrap from here to zero even when Depth is not a power of two.
    localparam logic [BufferWidth-1:0] LP_LAST  = BufferWidth'(Depth - 1);
    localparam logic [CountWidth:0]    LP_DEPTH = (CountWidth + 1)'(Depth);

    logic [BufferWidth-1:0] r_wr_ptr;
    logic [BufferWidth-1:0] r_rd_ptr;
    logic [BufferWidth-1:0] r_mark_ptr;
    logic [CountWidth-1:0]  r_count;
    logic [CountWidth-1:0]  r_replay;
    logic                   r_mark_valid;
    logic                   r_err;

    logic [CountWidth:0]    w_occupancy;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_rewind_hit;

    logic [BufferWidth-1:0] w_wr_ptr_nxt;
    logic [BufferWidth-1:0] w_rd_ptr_nxt;
    logic [BufferWidth-1:0] w_mark_ptr_nxt;
    logic [CountWidth-1:0]  w_count_nxt;
    logic [CountWidth-1:0]  w_replay_nxt;
    logic                   w_mark_valid_nxt;
    logic                   w_err_nxt;

    function automatic logic [BufferWidth-1:0] f_next_ptr(input logic [BufferWidth-1:0] p);
        return (p == LP_LAST) ? '0 : p + BufferWidth'(1);
    endfunction

    // Replayable entries still occupy RAM, so they count against capacity; flags use registered state only.
    assign w_occupancy  = {1'b0, r_count} + {1'b0, r_replay};
    assign w_full       = (w_occupancy == LP_DEPTH);
    assign w_empty      = (r_count == '0);
    assign w_wr_acc     = WrEN & ~w_full;
    assign w_rd_acc     = RdEN & ~w_empty & ~Rewind;
    assign w_rewind_hit = Rewind & r_mark_valid;

    // Next-state: pointer advance, occupancy bookkeeping and the Rewind > Mark > Release control priority.
    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_mark_ptr_nxt   = r_mark_ptr;
        w_mark_valid_nxt = r_mark_valid;
        w_replay_nxt     = '0;
        w_err_nxt        = r_err | (WrEN & w_full) | (RdEN & w_empty & ~Rewind);

        if (w_wr_acc) begin
            w_wr_ptr_nxt = f_next_ptr(r_wr_ptr);
        end
        if (w_rewind_hit) begin
            w_rd_ptr_nxt = r_mark_ptr;
        end else if (w_rd_acc) begin
            w_rd_ptr_nxt = f_next_ptr(r_rd_ptr);
        end

        // A rewind hands the replayed entries back to the unread pool; reads are blocked that cycle.
        w_count_nxt = r_count + (w_rewind_hit ? r_replay : '0)
                    + CountWidth'(w_wr_acc) - CountWidth'(w_rd_acc);

        if (Rewind) begin
            w_replay_nxt = '0;
        end else if (Mark) begin
            w_mark_ptr_nxt   = r_rd_ptr;
            w_mark_valid_nxt = 1'b1;
            w_replay_nxt     = CountWidth'(w_rd_acc);
        end else if (Release) begin
            w_mark_valid_nxt = 1'b0;
            w_replay_nxt     = '0;
        end else if (r_mark_valid) begin
            w_replay_nxt = r_replay + CountWidth'(w_rd_acc);
        end
    end

    // State register with synchronous clear that also discards any active mark.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_mark_ptr   <= '0;
            r_count      <= '0;
            r_replay     <= '0;
            r_mark_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_mark_ptr   <= w_mark_ptr_nxt;
            r_count      <= w_count_nxt;
            r_replay     <= w_replay_nxt;
            r_mark_valid <= w_mark_valid_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign WrAccept  = w_wr_acc;
    assign RdAccept  = w_rd_acc;
    assign WrPointer = r_wr_ptr;
    assign RdPointer = r_rd_ptr;
    assign Count     = r_count;
    assign Replay    = r_replay;
    assign MarkValid = r_mark_valid;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Err       = r_err;

endmodule
